// File: rtl/shared_reg_write_arbiter_pkg.sv
// Shared definitions for the shared register write arbiter: FSM state
// encoding, owner index width and a one-hot encode helper.
package shared_reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int OWNER_W  = 3;
  localparam int MAX_NREQ = 8;

  // One-hot encode of a requester index; callers truncate to their NREQ.
  function automatic logic [MAX_NREQ-1:0] onehot_enc(input logic [OWNER_W-1:0] idx);
    logic [MAX_NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/shared_reg_write_arbiter_prio_pick.sv
// Combinational winner picker. mode=0 picks the highest set request index;
// mode=1 searches cyclically starting just after rr_ptr.
module arb_prio_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] rr_ptr,
  input  logic               mode,
  output logic               any,
  output logic [OWNER_W-1:0] idx
);

  // Select the winning index according to the active arbitration mode.
  always_comb begin
    int  j;
    logic found;
    any   = |req;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (!mode) begin
      // Later (higher) indices overwrite earlier ones, so the highest wins.
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) idx = OWNER_W'(i);
      end
    end else begin
      // rr_ptr itself is visited last, giving it the lowest priority.
      for (int k = 1; k <= NREQ; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!found && req[j]) begin
          idx   = OWNER_W'(j);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Shared register write arbiter: serialises writes from NREQ agents into one
// WIDTH-bit register, with optional exclusive ownership bounded by MAX_HOLD.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | all requesters compete; winner writes, may lock ownership
//   OWNED | only the owner is served until it drops lock or times out
module shared_reg_write_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int WIDTH    = 2,
  parameter int RR       = 0,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]      q,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [OWNER_W-1:0]    owner,
  output logic                  timeout
);

  localparam int HCW = $clog2(MAX_HOLD) + 1;

  arb_state_e           state_q, state_d;
  logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic                 timeout_q, timeout_d;

  logic                 win_any;
  logic [OWNER_W-1:0]   win_idx;
  logic                 win_lock;
  logic [WIDTH-1:0]     win_data;
  logic                 own_req;
  logic                 own_lock;
  logic [WIDTH-1:0]     own_data;

  arb_prio_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .mode   (RR != 0),
    .any    (win_any),
    .idx    (win_idx)
  );

  // Mux out the winner's and the owner's request, lock and data lanes.
  always_comb begin
    win_lock = 1'b0;
    win_data = '0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == OWNER_W'(i)) begin
        win_lock = lock[i];
        win_data = wdata[i*WIDTH +: WIDTH];
      end
      if (owner_q == OWNER_W'(i)) begin
        own_req  = req[i];
        own_lock = lock[i];
        own_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state, write and ownership decisions for the coming edge.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    q_d        = q_q;
    gnt_d      = '0;
    busy_d     = busy_q;
    owner_d    = owner_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          q_d   = win_data;
          gnt_d = NREQ'(onehot_enc(win_idx));
          if (RR != 0) rr_ptr_d = win_idx;
          if (win_lock) begin
            state_d    = OWNED;
            owner_d    = win_idx;
            hold_cnt_d = HCW'(1);
            busy_d     = 1'b1;
          end
        end
      end
      OWNED: begin
        if (own_req) begin
          q_d   = own_data;
          gnt_d = NREQ'(onehot_enc(owner_q));
        end
        // Release edges serve only the owner; others wait one more edge.
        if (!own_lock) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HCW'(MAX_HOLD - 1)) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          timeout_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rr_ptr_q   <= OWNER_W'(NREQ - 1);
      q_q        <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      q_q        <= q_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      timeout_q  <= timeout_d;
    end
  end

  assign q       = q_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule
